fetch_queue: RTL



---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: the enqueue side (in_*) and the dequeue side (out_*).
// The master modport is the producer/consumer environment; the slave modport is the queue.
interface fetch_queue_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO between fetch and decode, with
// end-of-trace detection on zero instructions. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    fetch_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trace_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = INSTR_W + PC_W;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          in_ready_i;
    logic          zero_instr;
    logic          accept;
    logic          enq;
    logic          deq;
    logic          bypass;
    logic [EW-1:0] head;

    // Full-ness alone gates in_ready, so a full queue never enqueues even while draining.
    always_comb begin
        in_ready_i = 1'b0;
        zero_instr = 1'b0;
        accept     = 1'b0;
        enq        = 1'b0;
        deq        = 1'b0;
        bypass     = 1'b0;
        head       = mem[rd_ptr];

        in_ready_i = !rst && (count < CW'(DEPTH));
        zero_instr = (bus.in_instr == '0);
        accept     = bus.in_valid && in_ready_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = !rst && (count == '0) && bus.in_valid && !zero_instr && !flush;
        deq        = (count != '0) && bus.out_ready && !flush;
        enq        = accept && !zero_instr && !flush && !(bypass && bus.out_ready);
`else
        deq        = (count != '0) && bus.out_ready && !flush;
        enq        = accept && !zero_instr && !flush;
`endif
    end

    // Output mux: bypassed input, stored head, or zeros when nothing is presented.
    always_comb begin
        bus.in_ready  = in_ready_i;
        bus.out_valid = 1'b0;
        bus.out_instr = '0;
        bus.out_pc    = '0;
        if (bypass) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.in_instr;
            bus.out_pc    = bus.in_pc;
        end else if (count != '0) begin
            bus.out_valid = 1'b1;
            bus.out_instr = head[EW-1:PC_W];
            bus.out_pc    = head[PC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {bus.in_instr, bus.in_pc};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            trace_done <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            trace_done <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
            if (accept && zero_instr) begin
                trace_done <= 1'b1;
            end
        end
    end
endmodule
